// File: rtl/key_updown_ledbar.sv
// Debounced up/down/clear keys drive a CNT_W-bit up/down counter and a binary/one-hot/bar LED bank.
// Define AUTO_REPEAT_EN to add hold-to-repeat on the up and down keys.
module key_updown_ledbar #(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned DEB_CYC    = 500000,
  parameter bit          KEY_ACT_LO = 1'b1,
  parameter bit          WRAP       = 1'b1,
  parameter int unsigned LED_MODE   = 0
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 key_up,
  input  logic                                                 key_dn,
  input  logic                                                 key_clr,
  output logic [((LED_MODE == 0) ? CNT_W : (1 << CNT_W)) - 1:0] led,
  output logic [CNT_W-1:0]                                     cnt,
  output logic                                                 evt
);

  localparam int unsigned LED_N = (LED_MODE == 0) ? CNT_W : (1 << CNT_W);
  localparam int unsigned DW = $clog2(DEB_CYC);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LED_N-1:0] LED_RST = (LED_MODE == 0) ? '0 : LED_N'(1);

  // Key index: 0 = up, 1 = down, 2 = clear; 1 means pressed after normalisation.
  logic [2:0]    key_raw;
  logic [2:0]    key_nrm;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [1:0]    sync_vld;
  logic [2:0]    stable;
  logic [2:0]    press;
  logic [2:0]    armed;
  logic [DW-1:0] deb_cnt [3];

  logic             step_up;
  logic             step_dn;
  logic             step_clr;
  logic [CNT_W-1:0] cnt_nxt;
  logic             chg;
  logic [LED_N-1:0] led_nxt;

  assign key_raw = {key_clr, key_dn, key_up};
  assign key_nrm = KEY_ACT_LO ? ~key_raw : key_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= '0;
      sync2    <= '0;
      sync_vld <= '0;
    end else begin
      sync1    <= key_nrm;
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  // A key held through reset must be seen released before it can raise a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed <= '0;
    end else begin
      armed <= armed | ({3{sync_vld[1]}} & ~sync2);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= '0;
      press  <= '0;
      for (int k = 0; k < 3; k++) deb_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        press[k] <= 1'b0;
        if (sync2[k] == stable[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == DEB_LAST) begin
          deb_cnt[k] <= '0;
          stable[k]  <= sync2[k];
          press[k]   <= sync2[k] & armed[k];
        end else begin
          deb_cnt[k] <= deb_cnt[k] + DW'(1);
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_DLY = DEB_CYC * 50;
  localparam int unsigned RPT_PER = DEB_CYC * 10;
  localparam int unsigned RW = $clog2(RPT_DLY);
  localparam logic [RW-1:0] RPT_LAST = RW'(RPT_DLY - 1);
  localparam logic [RW-1:0] RPT_RLD  = RW'(RPT_DLY - RPT_PER);

  logic [RW-1:0] rpt_tmr [2];
  logic [1:0]    rpt_stop;
  logic [1:0]    rpt_pls;

  // Timer only advances while the synced pin still reads pressed, so the
  // debounce tail of a release cannot sneak in one more repeat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_stop <= '0;
      rpt_pls  <= '0;
      for (int k = 0; k < 2; k++) rpt_tmr[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        rpt_pls[k] <= 1'b0;
        if (!stable[k]) begin
          rpt_tmr[k]  <= '0;
          rpt_stop[k] <= 1'b0;
        end else if (press[2]) begin
          rpt_tmr[k]  <= '0;
          rpt_stop[k] <= 1'b1;
        end else if (!rpt_stop[k] && armed[k] && sync2[k]) begin
          if (rpt_tmr[k] == RPT_LAST) begin
            rpt_pls[k] <= 1'b1;
            rpt_tmr[k] <= RPT_RLD;
          end else begin
            rpt_tmr[k] <= rpt_tmr[k] + RW'(1);
          end
        end
      end
    end
  end

  assign step_up  = press[0] | rpt_pls[0];
  assign step_dn  = press[1] | rpt_pls[1];
`else
  assign step_up  = press[0];
  assign step_dn  = press[1];
`endif
  assign step_clr = press[2];

  always_comb begin
    cnt_nxt = cnt;
    if (step_clr) begin
      cnt_nxt = '0;
    end else if (!(step_up && step_dn)) begin
      if (step_up) begin
        if (cnt == CNT_MAX) cnt_nxt = WRAP ? '0 : cnt;
        else                cnt_nxt = cnt + CNT_W'(1);
      end else if (step_dn) begin
        if (cnt == '0) cnt_nxt = WRAP ? CNT_MAX : cnt;
        else           cnt_nxt = cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    led_nxt = '0;
    if (LED_MODE == 0) begin
      led_nxt = LED_N'(cnt);
    end else begin
      for (int i = 0; i < int'(LED_N); i++) begin
        led_nxt[i] = (LED_MODE == 1) ? (i == int'(cnt)) : (i <= int'(cnt));
      end
    end
  end

  // evt trails the counter by one cycle so it lines up with the registered LEDs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      chg <= 1'b0;
      evt <= 1'b0;
      led <= LED_RST;
    end else begin
      cnt <= cnt_nxt;
      chg <= (cnt_nxt != cnt);
      evt <= chg;
      led <= led_nxt;
    end
  end

endmodule

// File: tb/tb_key_updown_ledbar.sv
// Directed bench: three DUT copies (wrap/binary, saturate/bar, wrap/one-hot) share the same keys.
module tb_key_updown_ledbar;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_up;
  logic        key_dn;
  logic        key_clr;
  logic [3:0]  led_a;
  logic [15:0] led_b;
  logic [15:0] led_c;
  logic [3:0]  cnt_a;
  logic [3:0]  cnt_b;
  logic [3:0]  cnt_c;
  logic        evt_a;
  logic        evt_b;
  logic        evt_c;

  int total = 0;
  int bad   = 0;
  logic [3:0] ca = 4'd0;
  logic [3:0] cb = 4'd0;
  logic [3:0] cc = 4'd0;
  logic [3:0] rpt_exp;

  always #5 clk = ~clk;

  key_updown_ledbar #(.CNT_W(4), .DEB_CYC(4), .KEY_ACT_LO(1'b1), .WRAP(1'b1), .LED_MODE(0)) u_a (
    .clk(clk), .rst(rst), .key_up(key_up), .key_dn(key_dn), .key_clr(key_clr),
    .led(led_a), .cnt(cnt_a), .evt(evt_a)
  );
  key_updown_ledbar #(.CNT_W(4), .DEB_CYC(4), .KEY_ACT_LO(1'b1), .WRAP(1'b0), .LED_MODE(2)) u_b (
    .clk(clk), .rst(rst), .key_up(key_up), .key_dn(key_dn), .key_clr(key_clr),
    .led(led_b), .cnt(cnt_b), .evt(evt_b)
  );
  key_updown_ledbar #(.CNT_W(4), .DEB_CYC(4), .KEY_ACT_LO(1'b1), .WRAP(1'b1), .LED_MODE(1)) u_c (
    .clk(clk), .rst(rst), .key_up(key_up), .key_dn(key_dn), .key_clr(key_clr),
    .led(led_c), .cnt(cnt_c), .evt(evt_c)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("idle_evt", {13'd0, evt_a, evt_b, evt_c}, 16'd0);
    end
  endtask

  function automatic logic [15:0] bar(input logic [3:0] v);
    logic [16:0] t;
    t = (17'd2 << v) - 17'd1;
    return t[15:0];
  endfunction

  function automatic logic [15:0] onehot(input logic [3:0] v);
    return 16'd1 << v;
  endfunction

  // m = {clr, dn, up}; keys pressed together on one edge, held 8 edges, then released.
  task automatic press_chk(input logic [2:0] m, input logic [3:0] ea, input logic [3:0] eb,
                           input logic [3:0] ec, input string tag);
    {key_clr, key_dn, key_up} = ~m;
    wait_edges(7);
    chk({tag, "_cnt_a"}, cnt_a, ea);
    chk({tag, "_cnt_b"}, cnt_b, eb);
    chk({tag, "_cnt_c"}, cnt_c, ec);
    wait_edges(1);
    chk({tag, "_evt_a"}, evt_a, ea != ca);
    chk({tag, "_evt_b"}, evt_b, eb != cb);
    chk({tag, "_evt_c"}, evt_c, ec != cc);
    chk({tag, "_led_a"}, led_a, ea);
    chk({tag, "_led_b"}, led_b, bar(eb));
    chk({tag, "_led_c"}, led_c, onehot(ec));
    ca = ea;
    cb = eb;
    cc = ec;
    {key_clr, key_dn, key_up} = 3'b111;
    idle(12);
    chk({tag, "_rel_cnt"}, {cnt_a, cnt_b, cnt_c, 4'd0}, {ea, eb, ec, 4'd0});
  endtask

  initial begin
    // Reset with up held: no step until released and pressed again.
    rst = 1'b0; key_up = 1'b0; key_dn = 1'b1; key_clr = 1'b1;
    wait_edges(3);
    chk("rst_cnt", {cnt_a, cnt_b, cnt_c, 4'd0}, 16'd0);
    chk("rst_led_a", led_a, 16'd0);
    chk("rst_led_b", led_b, 16'h0001);
    chk("rst_led_c", led_c, 16'h0001);
    chk("rst_evt", {evt_a, evt_b, evt_c}, 16'd0);
    rst = 1'b1;
    idle(20);
    chk("held_cnt", {cnt_a, cnt_b, cnt_c, 4'd0}, 16'd0);
    key_up = 1'b1;
    idle(12);
    chk("held_rel_cnt", cnt_a, 16'd0);

    // Latency of a single up press.
    key_up = 1'b0;
    wait_edges(6);
    chk("lat_cnt_pre", cnt_a, 16'd0);
    wait_edges(1);
    chk("lat_cnt", cnt_a, 16'd1);
    chk("lat_evt_early", evt_a, 16'd0);
    chk("lat_led_early", led_a, 16'd0);
    wait_edges(1);
    chk("lat_led_a", led_a, 16'h0001);
    chk("lat_led_b", led_b, 16'h0003);
    chk("lat_led_c", led_c, 16'h0002);
    chk("lat_evt", {evt_a, evt_b, evt_c}, 16'h0007);
    wait_edges(1);
    chk("lat_evt_post", evt_a, 16'd0);
    idle(11);
    key_up = 1'b1;
    idle(12);
    chk("lat_hold_cnt", {cnt_a, cnt_b, cnt_c, 4'd0}, 16'h1110);
    ca = 4'd1; cb = 4'd1; cc = 4'd1;

    // Debounce: 3-edge glitch rejected, 4-edge press accepted.
    key_dn = 1'b0;
    wait_edges(3);
    key_dn = 1'b1;
    idle(12);
    chk("glitch3_cnt", {cnt_a, cnt_b, cnt_c, 4'd0}, 16'h1110);
    key_dn = 1'b0;
    wait_edges(4);
    key_dn = 1'b1;
    wait_edges(3);
    chk("pulse4_cnt", {cnt_a, cnt_b, cnt_c, 4'd0}, 16'd0);
    wait_edges(1);
    chk("pulse4_evt", {evt_a, evt_b, evt_c}, 16'h0007);
    idle(12);
    ca = 4'd0; cb = 4'd0; cc = 4'd0;

    // Wrap versus saturate at both ends.
    press_chk(3'b010, 4'd15, 4'd0, 4'd15, "dn_at_zero");
    press_chk(3'b001, 4'd0, 4'd1, 4'd0, "up_wrap");
    for (int i = 1; i <= 14; i++) press_chk(3'b001, 4'(i), 4'(i + 1), 4'(i), "climb");
    press_chk(3'b001, 4'd15, 4'd15, 4'd15, "up_sat");
    press_chk(3'b001, 4'd0, 4'd15, 4'd0, "up_wrap2");

    // Simultaneous presses.
    press_chk(3'b011, 4'd0, 4'd15, 4'd0, "up_dn_same");
    for (int i = 1; i <= 7; i++) press_chk(3'b001, 4'(i), 4'd15, 4'(i), "climb7");
    press_chk(3'b111, 4'd0, 4'd0, 4'd0, "clr_all");
    press_chk(3'b100, 4'd0, 4'd0, 4'd0, "clr_zero");

    // LED decode at cnt=3.
    for (int i = 1; i <= 3; i++) press_chk(3'b001, 4'(i), 4'(i), 4'(i), "to3");
    chk("led_bin3", led_a, 16'h0003);
    chk("led_bar3", led_b, 16'h000F);
    chk("led_hot3", led_c, 16'h0008);

    // Long hold: one step, plus six steps total when auto-repeat is built in.
`ifdef AUTO_REPEAT_EN
    rpt_exp = 4'd9;
`else
    rpt_exp = 4'd4;
`endif
    key_up = 1'b0;
    wait_edges(400);
    key_up = 1'b1;
    wait_edges(20);
    chk("hold400_a", cnt_a, rpt_exp);
    chk("hold400_b", cnt_b, rpt_exp);
    chk("hold400_c", cnt_c, rpt_exp);
    chk("hold400_evt", {evt_a, evt_b, evt_c}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
